month_year_counter: RTL and testbench

MONTH_YEAR_COUNTER -- requirements
Module: month_year_counter

---
 rtl/clock_pkg.sv | 14 +
 rtl/month_len_lut.sv | 36 +++
 rtl/month_year_counter.sv | 122 ++++++++++++
 tb/tb_month_year_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the calendar blocks: BCD digit width and the one-hot
// month-length codes exchanged between month_year_counter and century_clock.
package clock_pkg;
  localparam int BCD_W = 4;

  localparam logic [3:0] DM_31 = 4'b0001;
  localparam logic [3:0] DM_30 = 4'b0010;
  localparam logic [3:0] DM_29 = 4'b0100;
  localparam logic [3:0] DM_28 = 4'b1000;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/month_len_lut.sv
// Combinational month-length decode: maps a BCD month/year to the one-hot
// day_mode code, including the two-digit leap-year rule.
module month_len_lut import clock_pkg::*; (
  input  logic             month_ten,
  input  logic [BCD_W-1:0] month_unit,
  input  logic [BCD_W-1:0] year_ten,
  input  logic [BCD_W-1:0] year_unit,
  input  logic             leap_00,
  output logic [3:0]       day_mode
);
  logic leap;

  always_comb begin
    leap = 1'b0;
    // Divisible by 4 in BCD: even tens need units 0/4/8, odd tens need 2/6.
    if (year_ten == 4'd0 && year_unit == 4'd0)
      leap = leap_00;
    else if (!year_ten[0])
      leap = (year_unit == 4'd0) || (year_unit == 4'd4) || (year_unit == 4'd8);
    else
      leap = (year_unit == 4'd2) || (year_unit == 4'd6);
  end

  always_comb begin
    day_mode = DM_31;
    if (!month_ten) begin
      case (month_unit)
        4'd2:                 day_mode = leap ? DM_29 : DM_28;
        4'd4, 4'd6, 4'd9:     day_mode = DM_30;
        default:              day_mode = DM_31;
      endcase
    end else if (month_unit == 4'd1) begin
      day_mode = DM_30;
    end
  end
endmodule

// File: rtl/month_year_counter.sv
// BCD month (01..12) / year (00..99) counter advanced by the day-wrap carry,
// with a validated date-load port and registered month-length output.
module month_year_counter import clock_pkg::*; #(
  parameter logic LEAP_00 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pulse_day,
  input  logic             load,
  input  logic             load_month_ten,
  input  logic [BCD_W-1:0] load_month_unit,
  input  logic [BCD_W-1:0] load_year_ten,
  input  logic [BCD_W-1:0] load_year_unit,
  output logic             month_ten,
  output logic [BCD_W-1:0] month_unit,
  output logic [BCD_W-1:0] year_ten,
  output logic [BCD_W-1:0] year_unit,
  output logic [3:0]       day_mode,
  output logic             pulse_year,
  output logic             pulse_century,
  output logic             load_err
);
  logic             month_ten_q, month_ten_d;
  logic [BCD_W-1:0] month_unit_q, month_unit_d;
  logic [BCD_W-1:0] year_ten_q, year_ten_d;
  logic [BCD_W-1:0] year_unit_q, year_unit_d;
  logic [3:0]       day_mode_q, day_mode_d;
  logic             pulse_year_q, pulse_year_d;
  logic             pulse_century_q, pulse_century_d;
  logic             load_err_q, load_err_d;
  logic             month_legal, load_ok;

  assign month_legal = load_month_ten ? (load_month_unit <= 4'd2)
                                      : (load_month_unit != 4'd0 && bcd_ok(load_month_unit));
  assign load_ok = month_legal && bcd_ok(load_year_ten) && bcd_ok(load_year_unit);

  always_comb begin
    month_ten_d     = month_ten_q;
    month_unit_d    = month_unit_q;
    year_ten_d      = year_ten_q;
    year_unit_d     = year_unit_q;
    pulse_year_d    = 1'b0;
    pulse_century_d = 1'b0;
    load_err_d      = 1'b0;

    // A load in the same cycle as a day carry swallows the carry.
    if (load) begin
      if (load_ok) begin
        month_ten_d  = load_month_ten;
        month_unit_d = load_month_unit;
        year_ten_d   = load_year_ten;
        year_unit_d  = load_year_unit;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en && pulse_day) begin
      if (month_ten_q && month_unit_q == 4'd2) begin
        month_ten_d  = 1'b0;
        month_unit_d = 4'd1;
        pulse_year_d = 1'b1;
        if (year_unit_q == 4'd9) begin
          year_unit_d = 4'd0;
          if (year_ten_q == 4'd9) begin
            year_ten_d      = 4'd0;
            pulse_century_d = 1'b1;
          end else begin
            year_ten_d = year_ten_q + 4'd1;
          end
        end else begin
          year_unit_d = year_unit_q + 4'd1;
        end
      end else if (month_unit_q == 4'd9) begin
        month_ten_d  = 1'b1;
        month_unit_d = 4'd0;
      end else begin
        month_unit_d = month_unit_q + 4'd1;
      end
    end
  end

  // Decode from the next-state date so day_mode lands with the new date.
  month_len_lut u_lut (
    .month_ten  (month_ten_d),
    .month_unit (month_unit_d),
    .year_ten   (year_ten_d),
    .year_unit  (year_unit_d),
    .leap_00    (LEAP_00),
    .day_mode   (day_mode_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      month_ten_q     <= 1'b0;
      month_unit_q    <= 4'd1;
      year_ten_q      <= 4'd0;
      year_unit_q     <= 4'd0;
      day_mode_q      <= DM_31;
      pulse_year_q    <= 1'b0;
      pulse_century_q <= 1'b0;
      load_err_q      <= 1'b0;
    end else begin
      month_ten_q     <= month_ten_d;
      month_unit_q    <= month_unit_d;
      year_ten_q      <= year_ten_d;
      year_unit_q     <= year_unit_d;
      day_mode_q      <= day_mode_d;
      pulse_year_q    <= pulse_year_d;
      pulse_century_q <= pulse_century_d;
      load_err_q      <= load_err_d;
    end
  end

  assign month_ten     = month_ten_q;
  assign month_unit    = month_unit_q;
  assign year_ten      = year_ten_q;
  assign year_unit     = year_unit_q;
  assign day_mode      = day_mode_q;
  assign pulse_year    = pulse_year_q;
  assign pulse_century = pulse_century_q;
  assign load_err      = load_err_q;
endmodule

// File: tb/tb_month_year_counter.sv
// Bench for month_year_counter: a directed vector table, hand-written
// rollover/reset sequences and a random run against an integer calendar model.
module tb_month_year_counter;
  logic       clk = 1'b0;
  logic       rst_n, en, pulse_day, load, load_month_ten;
  logic [3:0] load_month_unit, load_year_ten, load_year_unit;

  logic       mt1, py1, pc1, le1, mt0, py0, pc0, le0;
  logic [3:0] mu1, yt1, yu1, dm1, mu0, yt0, yu0, dm0;
  logic [19:0] act1, act0;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Reference calendar as plain integers.
  int m_month = 1, m_year = 0;
  bit m_py = 0, m_pc = 0, m_le = 0;

  always #5 clk = ~clk;

  month_year_counter #(.LEAP_00(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_day(pulse_day), .load(load),
    .load_month_ten(load_month_ten), .load_month_unit(load_month_unit),
    .load_year_ten(load_year_ten), .load_year_unit(load_year_unit),
    .month_ten(mt1), .month_unit(mu1), .year_ten(yt1), .year_unit(yu1),
    .day_mode(dm1), .pulse_year(py1), .pulse_century(pc1), .load_err(le1));

  month_year_counter #(.LEAP_00(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_day(pulse_day), .load(load),
    .load_month_ten(load_month_ten), .load_month_unit(load_month_unit),
    .load_year_ten(load_year_ten), .load_year_unit(load_year_unit),
    .month_ten(mt0), .month_unit(mu0), .year_ten(yt0), .year_unit(yu0),
    .day_mode(dm0), .pulse_year(py0), .pulse_century(pc0), .load_err(le0));

  assign act1 = {mt1, mu1, yt1, yu1, dm1, py1, pc1, le1};
  assign act0 = {mt0, mu0, yt0, yu0, dm0, py0, pc0, le0};

  function automatic logic [3:0] exp_dm(int mo, int yr, bit l00);
    bit leap;
    leap = (yr == 0) ? l00 : (yr % 4 == 0);
    case (mo)
      2:             return leap ? 4'b0100 : 4'b1000;
      4, 6, 9, 11:   return 4'b0010;
      default:       return 4'b0001;
    endcase
  endfunction

  function automatic logic [19:0] model_vec(bit l00);
    return {1'(m_month / 10), 4'(m_month % 10), 4'(m_year / 10), 4'(m_year % 10),
            exp_dm(m_month, m_year, l00), m_py, m_pc, m_le};
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit p, input bit l,
                            input int lmt, input int lmu, input int lyt, input int lyu);
    int mo;
    m_py = 0; m_pc = 0; m_le = 0;
    mo = lmt * 10 + lmu;
    if (!r) begin
      m_month = 1; m_year = 0;
    end else if (l) begin
      if (lmt <= 1 && lmu <= 9 && lyt <= 9 && lyu <= 9 && mo >= 1 && mo <= 12) begin
        m_month = mo; m_year = lyt * 10 + lyu;
      end else begin
        m_le = 1;
      end
    end else if (e && p) begin
      if (m_month == 12) begin
        m_month = 1; m_py = 1;
        if (m_year == 99) begin m_year = 0; m_pc = 1; end
        else m_year = m_year + 1;
      end else begin
        m_month = m_month + 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit p, input bit l,
                      input logic lmt, input logic [3:0] lmu, input logic [3:0] lyt,
                      input logic [3:0] lyu);
    rst_n = r; en = e; pulse_day = p; load = l;
    load_month_ten = lmt; load_month_unit = lmu; load_year_ten = lyt; load_year_unit = lyu;
    @(posedge clk);
    #1;
    model_edge(r, e, p, l, int'(lmt), int'(lmu), int'(lyt), int'(lyu));
    txn++;
    $display("txn %0d rst_n=%0b en=%0b pd=%0b load=%0b -> %0d%0h/%0h%0h dm=%b py=%0b pc=%0b le=%0b",
             txn, r, e, p, l, mt1, mu1, yt1, yu1, dm1, py1, pc1, le1);
    chk("model_leap00_1", act1, model_vec(1'b1));
    chk("model_leap00_0", act0, model_vec(1'b0));
  endtask

  typedef struct {
    bit en; bit pd; bit ld;
    logic lmt; logic [3:0] lmu; logic [3:0] lyt; logic [3:0] lyu;
    logic [7:0] emon; logic [7:0] eyr; logic [3:0] edm; logic [3:0] edm0;
    bit epy; bit epc; bit ele;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1, 0, 1, 1'b0, 4'd2, 4'd2, 4'd4, 8'h02, 8'h24, 4'b0100, 4'b0100, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 1'b0, 4'd2, 4'd2, 4'd3, 8'h02, 8'h23, 4'b1000, 4'b1000, 0, 0, 0};
    vecs[2]  = '{1, 0, 1, 1'b0, 4'd2, 4'd0, 4'd0, 8'h02, 8'h00, 4'b0100, 4'b1000, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 1'b1, 4'd3, 4'd0, 4'd5, 8'h02, 8'h00, 4'b0100, 4'b1000, 0, 0, 1};
    vecs[4]  = '{1, 0, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h02, 8'h00, 4'b0100, 4'b1000, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 1'b0, 4'd3, 4'hA, 4'd5, 8'h02, 8'h00, 4'b0100, 4'b1000, 0, 0, 1};
    vecs[6]  = '{1, 1, 1, 1'b0, 4'd6, 4'd5, 4'd0, 8'h06, 8'h50, 4'b0010, 4'b0010, 0, 0, 0};
    vecs[7]  = '{1, 0, 1, 1'b1, 4'd2, 4'd9, 4'd9, 8'h12, 8'h99, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[8]  = '{1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h01, 8'h00, 4'b0001, 4'b0001, 1, 1, 0};
    vecs[9]  = '{1, 0, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h01, 8'h00, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[10] = '{1, 0, 1, 1'b0, 4'd9, 4'd0, 4'd8, 8'h09, 8'h08, 4'b0010, 4'b0010, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h10, 8'h08, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[12] = '{1, 1, 1, 1'b0, 4'd1, 4'd0, 4'd9, 8'h01, 8'h09, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[13] = '{1, 0, 1, 1'b1, 4'd2, 4'd0, 4'd9, 8'h12, 8'h09, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[14] = '{1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h01, 8'h10, 4'b0001, 4'b0001, 1, 0, 0};
    vecs[15] = '{1, 0, 1, 1'b0, 4'd0, 4'd1, 4'd2, 8'h01, 8'h10, 4'b0001, 4'b0001, 0, 0, 1};
    vecs[16] = '{0, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h01, 8'h10, 4'b0001, 4'b0001, 0, 0, 0};
    vecs[17] = '{1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h02, 8'h10, 4'b1000, 4'b1000, 0, 0, 0};

    // Reset state.
    step(0, 0, 0, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("reset_state", act1, {1'b0, 4'd1, 4'd0, 4'd0, 4'b0001, 3'b000});

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      step(1, vecs[i].en, vecs[i].pd, vecs[i].ld, vecs[i].lmt, vecs[i].lmu, vecs[i].lyt, vecs[i].lyu);
      chk($sformatf("vec%0d_leap1", i), act1,
          {vecs[i].emon[4], vecs[i].emon[3:0], vecs[i].eyr, vecs[i].edm, vecs[i].epy, vecs[i].epc, vecs[i].ele});
      chk($sformatf("vec%0d_leap0", i), act0,
          {vecs[i].emon[4], vecs[i].emon[3:0], vecs[i].eyr, vecs[i].edm0, vecs[i].epy, vecs[i].epc, vecs[i].ele});
    end

    // Full year from reset: 11 pulses reach December, the 12th rolls the year.
    step(0, 0, 0, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 11; i++) begin
      step(1, 1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0);
      step(1, 1, 0, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    end
    chk("eleven_pulses", act1, {1'b1, 4'd2, 4'd0, 4'd0, 4'b0001, 3'b000});
    step(1, 1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("twelfth_pulse", act1, {1'b0, 4'd1, 4'd0, 4'd1, 4'b0001, 3'b100});
    step(1, 1, 0, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("pulse_year_one_cycle", act1, {1'b0, 4'd1, 4'd0, 4'd1, 4'b0001, 3'b000});

    // Disabled counting ignores pulses.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("en_low_hold", act1, {1'b0, 4'd1, 4'd0, 4'd1, 4'b0001, 3'b000});

    // Held pulse_day advances one month per cycle, across a year boundary.
    for (int i = 0; i < 14; i++) step(1, 1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("held_pulse", act1, {1'b0, 4'd3, 4'd0, 4'd2, 4'b0001, 3'b000});

    // Reset wins over a pending 12/99 rollover and over a load.
    step(1, 0, 0, 1, 1'b1, 4'd2, 4'd9, 4'd9);
    step(0, 1, 1, 0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("reset_mid_rollover", act1, {1'b0, 4'd1, 4'd0, 4'd0, 4'b0001, 3'b000});
    step(0, 1, 1, 1, 1'b1, 4'd2, 4'd9, 4'd9);
    chk("reset_over_load", act1, {1'b0, 4'd1, 4'd0, 4'd0, 4'b0001, 3'b000});

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r, e, p, l;
      logic lmt;
      logic [3:0] lmu, lyt, lyu;
      int mo, yr;
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 3) != 0);
      p = $urandom_range(0, 1) != 0;
      l = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0) begin
        mo = $urandom_range(1, 12); yr = $urandom_range(0, 99);
        lmt = 1'(mo / 10); lmu = 4'(mo % 10); lyt = 4'(yr / 10); lyu = 4'(yr % 10);
      end else begin
        lmt = 1'($urandom_range(0, 1)); lmu = 4'($urandom_range(0, 15));
        lyt = 4'($urandom_range(0, 15)); lyu = 4'($urandom_range(0, 15));
      end
      step(r, e, p, l, lmt, lmu, lyt, lyu);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
